// File: rtl/tdm_link_pkg.sv
// Shared definitions for the active-low framed TDM link (transmitter and receiver-side checker).
package tdm_link_pkg;
  localparam int NUM_CH = 4;
  localparam int DATA_BITS = 8;
  localparam int CH_W = 2;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tdm_state_e;

  function automatic logic [CH_W-1:0] nextCh(input logic [CH_W-1:0] ch);
    return ch + CH_W'(1);
  endfunction
endpackage

// File: rtl/tdm_selector41_tx_if.sv
// Source-side bundle of the TDM transmitter: four byte sources, the serial line and the select pair.
interface tdm_selector41_tx_if;
  import tdm_link_pkg::*;

  // Handshake: a byte moves on a rising edge where iValid[k] && oReady[k]; while iValid[k]
  // is high the source holds iDatak stable, and oReady is at most one-hot.
  logic [DATA_BITS-1:0] iData0;
  logic [DATA_BITS-1:0] iData1;
  logic [DATA_BITS-1:0] iData2;
  logic [DATA_BITS-1:0] iData3;
  logic [NUM_CH-1:0]    iValid;
  logic [NUM_CH-1:0]    oReady;
  logic                 oC;
  logic                 oS1;
  logic                 oS0;
  logic                 oBusy;
  tdm_state_e           dbgState;

  modport master (
    output iData0, iData1, iData2, iData3, iValid,
    input  oReady, oC, oS1, oS0, oBusy, dbgState
  );

  modport slave (
    input  iData0, iData1, iData2, iData3, iValid,
    output oReady, oC, oS1, oS0, oBusy, dbgState
  );
endinterface

// File: rtl/tdm_selector41_tx_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester found searching upward from ptr (mod 4).
module rr_arbiter4
  import tdm_link_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grantIdx
);
  logic            found;
  logic [CH_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + CH_W'(i);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
  end
endmodule

// File: rtl/tdm_selector41_tx.sv
// Round-robin 4-source serialiser: frames each byte as start/8 data LSB-first/stop on oC and
// steers it with {oS1,oS0}, which only moves on the accept edge while the line is idle-high.
module tdm_selector41_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = tdm_link_pkg::DATA_BITS
) (
  input logic               iClk,
  input logic               iRst_n,
  tdm_selector41_tx_if.slave link
);
  import tdm_link_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  tdm_state_e           state, stateNext;
  logic [CNT_W-1:0]     cycCnt, cycNext;
  logic [2:0]           bitCnt, bitNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic [CH_W-1:0]      ptr, ptrNext;
  logic [CH_W-1:0]      sel, selNext;
  logic                 lineC, lineNext;
  logic                 busy;
  logic                 slotEnd;

  logic [NUM_CH-1:0]    grant;
  logic [CH_W-1:0]      grantIdx;
  logic [DATA_BITS-1:0] dataMux;

  rr_arbiter4 u_arb (
    .req      (link.iValid),
    .ptr      (ptr),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  always_comb begin
    dataMux = link.iData0;
    unique case (grantIdx)
      2'd0:    dataMux = link.iData0;
      2'd1:    dataMux = link.iData1;
      2'd2:    dataMux = link.iData2;
      default: dataMux = link.iData3;
    endcase
  end

  always_comb begin
    stateNext = state;
    cycNext   = cycCnt;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    ptrNext   = ptr;
    selNext   = sel;
    lineNext  = LINE_IDLE;
    slotEnd   = (cycCnt == CNT_LAST);
    unique case (state)
      ST_IDLE: begin
        if (|grant) begin
          stateNext = ST_SETUP;
          cycNext   = '0;
          bitNext   = '0;
          shiftNext = dataMux;
          selNext   = grantIdx;
          ptrNext   = nextCh(grantIdx);
        end
      end
      ST_SETUP: begin
        // Line stays high one full slot so the de-selector settles on the new select.
        if (slotEnd) begin
          stateNext = ST_START;
          cycNext   = '0;
          lineNext  = START_LVL;
        end else begin
          cycNext = cycCnt + CNT_W'(1);
        end
      end
      ST_START: begin
        lineNext = START_LVL;
        if (slotEnd) begin
          stateNext = ST_DATA;
          cycNext   = '0;
          lineNext  = shiftReg[0];
        end else begin
          cycNext = cycCnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        lineNext = shiftReg[0];
        if (slotEnd) begin
          cycNext   = '0;
          shiftNext = shiftReg >> 1;
          if (bitCnt == BIT_LAST) begin
            stateNext = ST_STOP;
            lineNext  = LINE_IDLE;
          end else begin
            bitNext  = bitCnt + 3'd1;
            lineNext = shiftReg[1];
          end
        end else begin
          cycNext = cycCnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (slotEnd) begin
          stateNext = ST_IDLE;
          cycNext   = '0;
        end else begin
          cycNext = cycCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = ST_IDLE;
        cycNext   = '0;
        bitNext   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state    <= ST_IDLE;
      cycCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      ptr      <= '0;
      sel      <= '0;
      lineC    <= LINE_IDLE;
      busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      cycCnt   <= cycNext;
      bitCnt   <= bitNext;
      shiftReg <= shiftNext;
      ptr      <= ptrNext;
      sel      <= selNext;
      lineC    <= lineNext;
      busy     <= (stateNext != ST_IDLE);
    end
  end

  assign link.oReady   = (iRst_n && state == ST_IDLE) ? grant : '0;
  assign link.oC       = lineC;
  assign link.oS1      = sel[1];
  assign link.oS0      = sel[0];
  assign link.oBusy    = busy;
  assign link.dbgState = state;
endmodule

// File: tb/tb_tdm_selector41_tx.sv
// Bench for tdm_selector41_tx: frame-level reference model (expected line-level queue) plus scenario tasks.
module tb_tdm_selector41_tx;
  import tdm_link_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = 11 * CPB;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] data [NUM_CH];
  logic [3:0] valid = 4'b0000;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  tdm_selector41_tx_if link();
  assign link.iData0 = data[0];
  assign link.iData1 = data[1];
  assign link.iData2 = data[2];
  assign link.iData3 = data[3];
  assign link.iValid = valid;

  tdm_selector41_tx #(.CLKS_PER_BIT(CPB)) dut (
    .iClk   (clk),
    .iRst_n (rstN),
    .link   (link)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  logic [0:0] exp_q[$];
  logic [1:0] expSel = 2'b00;
  int         mPtr = 0;
  logic       prevC = 1'b1;
  logic [1:0] prevSel = 2'b00;
  int         obsCh[$];
  int         obsCyc[$];
  bit         acceptFlag = 1'b0;
  int         acceptCh = 0;
  bit         dropOnAccept = 1'b1;
  int         win;
  logic [3:0] expReady;
  logic [0:0] lvl;
  logic [1:0] curSel;

  always @(negedge clk) begin
    curSel = {link.oS1, link.oS0};
    for (int k = 0; k < NUM_CH; k++)
      if (link.oReady[k]) begin
        obsCh.push_back(k);
        obsCyc.push_back(cyc);
      end
    if (!rstN) begin
      total++;
      if (link.oReady !== 4'b0000) begin
        bad++;
        $display("FAIL reset_ready: oReady=%b required=0000", link.oReady);
      end
      exp_q.delete();
      expSel  = 2'b00;
      mPtr    = 0;
      prevC   = 1'b1;
      prevSel = 2'b00;
    end else begin
      total++;
      if (curSel !== expSel) begin
        bad++;
        $display("FAIL select @%0d: sel=%b required=%b", cyc, curSel, expSel);
      end
      if (curSel !== prevSel) begin
        total++;
        if (!(prevC === 1'b1 && link.oC === 1'b1)) begin
          bad++;
          $display("FAIL sel_guard @%0d: sel moved with oC prev=%b cur=%b required both 1", cyc, prevC, link.oC);
        end
      end
      if (exp_q.size() != 0) begin
        lvl = exp_q.pop_front();
        total++;
        if ({link.oC, link.oBusy, link.oReady} !== {lvl, 1'b1, 4'b0000}) begin
          bad++;
          $display("FAIL frame_line @%0d: oC=%b oBusy=%b oReady=%b required oC=%b oBusy=1 oReady=0000",
                   cyc, link.oC, link.oBusy, link.oReady, lvl);
        end
      end else begin
        win = -1;
        for (int i = 0; i < NUM_CH; i++)
          if (win < 0 && valid[(mPtr + i) % NUM_CH]) win = (mPtr + i) % NUM_CH;
        expReady = (win < 0) ? 4'b0000 : 4'(1 << win);
        total++;
        if ({link.oC, link.oBusy, link.oReady} !== {1'b1, 1'b0, expReady}) begin
          bad++;
          $display("FAIL idle_ready @%0d: oC=%b oBusy=%b oReady=%b required oC=1 oBusy=0 oReady=%b",
                   cyc, link.oC, link.oBusy, link.oReady, expReady);
        end
        if (win >= 0) begin
          for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
          for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
          for (int b = 0; b < 8; b++)
            for (int i = 0; i < CPB; i++) exp_q.push_back(data[win][b]);
          for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
          expSel     = 2'(win);
          mPtr       = (win + 1) % NUM_CH;
          acceptCh   = win;
          acceptFlag = 1'b1;
        end
      end
      prevC   = link.oC;
      prevSel = curSel;
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (acceptFlag) begin
      acceptFlag = 1'b0;
      data[acceptCh] = {2'(acceptCh), 6'($urandom_range(0, 63))};
      if (dropOnAccept) valid[acceptCh] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rstN = 1'b0;
    repeat (n) step();
    rstN = 1'b1;
  endtask

  task automatic wait_grants(input int want, input int budget, input string name);
    int t;
    t = 0;
    while (obsCh.size() < want && t < budget) begin
      step();
      t++;
    end
    if (obsCh.size() < want) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: grants=%0d required=%0d", name, obsCh.size(), want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    valid = 4'b1111;
    do_reset(3);
    valid = 4'b0000;
    @(negedge clk);
    total++;
    if ({link.oC, link.oS1, link.oS0, link.oBusy, link.oReady} !== 8'b1_0_0_0_0000 ||
        link.dbgState !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: oC=%b oS=%b%b oBusy=%b oReady=%b required 1 00 0 0000",
               link.oC, link.oS1, link.oS0, link.oBusy, link.oReady);
    end
    step();
  endtask

  task automatic test_idle();
    valid = 4'b0000;
    repeat (100) begin
      step();
      @(negedge clk);
      total++;
      if ({link.oC, link.oBusy, link.oReady} !== 6'b1_0_0000) begin
        bad++;
        $display("FAIL idle_quiet: oC=%b oBusy=%b oReady=%b required 1 0 0000", link.oC, link.oBusy, link.oReady);
      end
    end
  endtask

  task automatic test_single_frame();
    int         n0, busyCnt;
    logic [7:0] b;
    logic [45:0] gotC, expC;
    logic [1:0] firstSel;
    dropOnAccept = 1'b1;
    b = 8'hA5;
    data[2] = b;
    n0 = obsCh.size();
    valid = 4'b0100;
    wait_grants(n0 + 1, 20, "single");
    if (obsCh.size() <= n0) return;
    total++;
    if (obsCh[n0] !== 2) begin
      bad++;
      $display("FAIL single_grant: ch=%0d required=2", obsCh[n0]);
    end
    expC = '1;
    for (int i = 0; i < CPB; i++) expC[CPB + i] = 1'b0;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) expC[2 * CPB + k * CPB + i] = b[k];
    busyCnt = 0;
    firstSel = 2'b00;
    for (int s = 0; s < 46; s++) begin
      @(negedge clk);
      gotC[s] = link.oC;
      if (link.oBusy) busyCnt++;
      if (s == 0) firstSel = {link.oS1, link.oS0};
      step();
    end
    total++;
    if (gotC !== expC) begin
      bad++;
      $display("FAIL single_wave: oC=%b required=%b", gotC, expC);
    end
    total++;
    if (busyCnt !== FRAME) begin
      bad++;
      $display("FAIL single_busy: busy_cycles=%0d required=%0d", busyCnt, FRAME);
    end
    total++;
    if (firstSel !== 2'b10) begin
      bad++;
      $display("FAIL single_sel: sel=%b required=10", firstSel);
    end
    total++;
    if (obsCh.size() !== n0 + 1) begin
      bad++;
      $display("FAIL single_once: grants=%0d required=%0d", obsCh.size() - n0, 1);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int n0;
    do_reset(1);
    dropOnAccept = 1'b0;
    for (int k = 0; k < NUM_CH; k++) data[k] = {2'(k), 6'($urandom_range(0, 63))};
    n0 = obsCh.size();
    valid = 4'b1111;
    wait_grants(n0 + 5, 5 * (FRAME + 1) + 20, "rr");
    valid = 4'b0000;
    dropOnAccept = 1'b1;
    if (obsCh.size() < n0 + 5) return;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obsCh[n0 + i] !== order[i]) begin
        bad++;
        $display("FAIL rr_order[%0d]: ch=%0d required=%0d", i, obsCh[n0 + i], order[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      total++;
      if (obsCyc[n0 + i] - obsCyc[n0 + i - 1] !== FRAME + 1) begin
        bad++;
        $display("FAIL rr_spacing[%0d]: cycles=%0d required=%0d", i,
                 obsCyc[n0 + i] - obsCyc[n0 + i - 1], FRAME + 1);
      end
    end
    repeat (FRAME + 4) step();
  endtask

  task automatic test_priority();
    int n0;
    do_reset(1);
    dropOnAccept = 1'b1;
    n0 = obsCh.size();
    valid = 4'b0010;
    wait_grants(n0 + 1, 20, "prio_first");
    valid = 4'b1001;
    wait_grants(n0 + 3, 2 * (FRAME + 1) + 20, "prio");
    if (obsCh.size() < n0 + 3) return;
    total++;
    if ({obsCh[n0], obsCh[n0 + 1], obsCh[n0 + 2]} !== {32'sd1, 32'sd3, 32'sd0}) begin
      bad++;
      $display("FAIL prio_order: got %0d,%0d,%0d required 1,3,0", obsCh[n0], obsCh[n0 + 1], obsCh[n0 + 2]);
    end
    repeat (FRAME + 4) step();
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    do_reset(1);
    dropOnAccept = 1'b0;
    for (int k = 0; k < NUM_CH; k++) data[k] = 8'($urandom_range(0, 255));
    n0 = obsCh.size();
    valid = 4'b0001;
    wait_grants(n0 + 1, 20, "midrst_first");
    repeat (4 * CPB + 1) step();
    total++;
    if (link.dbgState !== ST_DATA) begin
      bad++;
      $display("FAIL midrst_where: state=%0d required DATA", link.dbgState);
    end
    rstN = 1'b0;
    @(negedge clk);
    total++;
    if (link.oReady !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_ready: oReady=%b required=0000", link.oReady);
    end
    n0 = obsCh.size();
    step();
    rstN = 1'b1;
    @(negedge clk);
    total++;
    if ({link.oC, link.oBusy, link.oS1, link.oS0} !== 4'b1_0_00) begin
      bad++;
      $display("FAIL midrst_state: oC=%b oBusy=%b oS=%b%b required 1 0 00",
               link.oC, link.oBusy, link.oS1, link.oS0);
    end
    step();
    total++;
    if (obsCh.size() !== n0 + 1 || obsCh[obsCh.size() - 1] !== 0) begin
      bad++;
      $display("FAIL midrst_restart: new_grants=%0d required 1 on ch0", obsCh.size() - n0);
    end
    valid = 4'b0000;
    dropOnAccept = 1'b1;
    repeat (FRAME + 4) step();
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) data[k] = 8'h00;
    test_reset();
    test_idle();
    test_single_frame();
    test_round_robin();
    test_priority();
    test_reset_mid_frame();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
